// File: rtl/ycbcr_pkg.sv
// Shared constants, types and helpers for the BT.709 colour-space converters.
package ycbcr_pkg;

  localparam int C_Y  = 298;
  localparam int C_RV = 459;
  localparam int C_GU = 55;
  localparam int C_GV = 136;
  localparam int C_BU = 541;

  localparam int Y_OFS    = 16;
  localparam int C_OFS    = 128;
  localparam int RND      = 128;
  localparam int PIPE_LAT = 4;

  // Forward (RGB -> YCbCr) gains, x256, limited range.
  localparam int F_YR = 47;
  localparam int F_YG = 157;
  localparam int F_YB = 16;
  localparam int F_UR = 26;
  localparam int F_UG = 87;
  localparam int F_UB = 112;
  localparam int F_VR = 112;
  localparam int F_VG = 102;
  localparam int F_VB = 10;

  typedef logic signed [19:0] sum_t;
  typedef logic signed [8:0]  ofs_t;

  function automatic logic [7:0] round_clamp(input sum_t s);
    sum_t t;
    t = (s + sum_t'(RND)) >>> 8;
    if (t < 0)
      return 8'd0;
    else if (t > 255)
      return 8'd255;
    else
      return t[7:0];
  endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register for video sync/enable bits.
// Synchronous active-low clear.
module sync_delay #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/ycbcr_to_rgb.sv
// Four-stage BT.709 limited-range YCbCr to RGB888 converter
// with sync/enable delayed to match the pixel data.
module ycbcr_to_rgb #(
  parameter bit BLANK_ZERO = 1'b1,
  parameter int C_Y  = ycbcr_pkg::C_Y,
  parameter int C_RV = ycbcr_pkg::C_RV,
  parameter int C_GU = ycbcr_pkg::C_GU,
  parameter int C_GV = ycbcr_pkg::C_GV,
  parameter int C_BU = ycbcr_pkg::C_BU
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ycbcr_y,
  input  logic [7:0] ycbcr_cb,
  input  logic [7:0] ycbcr_cr,
  input  logic       ycbcr_hs,
  input  logic       ycbcr_vs,
  input  logic       ycbcr_de,
  output logic [7:0] rgb_r,
  output logic [7:0] rgb_g,
  output logic [7:0] rgb_b,
  output logic       rgb_hs,
  output logic       rgb_vs,
  output logic       rgb_de
);

  import ycbcr_pkg::*;

  ofs_t yo, uo, vo;
  sum_t p_y, p_rv, p_gu, p_gv, p_bu;
  sum_t s_r, s_g, s_b;
  logic [7:0] r_q, g_q, b_q;
  logic [2:0] sq;
  logic blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      yo   <= '0;
      uo   <= '0;
      vo   <= '0;
      p_y  <= '0;
      p_rv <= '0;
      p_gu <= '0;
      p_gv <= '0;
      p_bu <= '0;
      s_r  <= '0;
      s_g  <= '0;
      s_b  <= '0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      yo   <= ofs_t'({1'b0, ycbcr_y})  - ofs_t'(Y_OFS);
      uo   <= ofs_t'({1'b0, ycbcr_cb}) - ofs_t'(C_OFS);
      vo   <= ofs_t'({1'b0, ycbcr_cr}) - ofs_t'(C_OFS);
      p_y  <= sum_t'(C_Y)  * sum_t'(yo);
      p_rv <= sum_t'(C_RV) * sum_t'(vo);
      p_gu <= sum_t'(C_GU) * sum_t'(uo);
      p_gv <= sum_t'(C_GV) * sum_t'(vo);
      p_bu <= sum_t'(C_BU) * sum_t'(uo);
      s_r  <= p_y + p_rv;
      s_g  <= p_y - p_gu - p_gv;
      s_b  <= p_y + p_bu;
      r_q  <= round_clamp(s_r);
      g_q  <= round_clamp(s_g);
      b_q  <= round_clamp(s_b);
    end
  end

  sync_delay #(
    .N(PIPE_LAT),
    .W(3)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({ycbcr_hs, ycbcr_vs, ycbcr_de}),
    .q    (sq)
  );

  assign rgb_hs = sq[2];
  assign rgb_vs = sq[1];
  assign rgb_de = sq[0];

  // Blanking uses the delayed de so it lines up with the S4 pixel.
  assign blank = BLANK_ZERO && !rgb_de;
  assign rgb_r = blank ? 8'd0 : r_q;
  assign rgb_g = blank ? 8'd0 : g_q;
  assign rgb_b = blank ? 8'd0 : b_q;

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Scoreboard bench: random and directed pixels vs an integer
// reference model, with reset flush and sync alignment.
module tb_ycbcr_to_rgb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ycbcr_y, ycbcr_cb, ycbcr_cr;
  logic       ycbcr_hs, ycbcr_vs, ycbcr_de;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic       rgb_hs, rgb_vs, rgb_de;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   running = 0;

  ycbcr_to_rgb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ycbcr_y (ycbcr_y),
    .ycbcr_cb(ycbcr_cb),
    .ycbcr_cr(ycbcr_cr),
    .ycbcr_hs(ycbcr_hs),
    .ycbcr_vs(ycbcr_vs),
    .ycbcr_de(ycbcr_de),
    .rgb_r   (rgb_r),
    .rgb_g   (rgb_g),
    .rgb_b   (rgb_b),
    .rgb_hs  (rgb_hs),
    .rgb_vs  (rgb_vs),
    .rgb_de  (rgb_de)
  );

  always #5 clk = ~clk;

  function automatic int floor256(input int v);
    if (v >= 0)
      return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic logic [7:0] chan(input int s);
    int t;
    t = floor256(s + 128);
    if (t < 0)
      t = 0;
    if (t > 255)
      t = 255;
    return 8'(t);
  endfunction

  function automatic exp_t model(input int y, input int cb,
                                 input int cr, input logic hs,
                                 input logic vs, input logic de);
    exp_t e;
    int yv, u, v;
    yv = 298 * (y - 16);
    u  = cb - 128;
    v  = cr - 128;
    e.hs = hs;
    e.vs = vs;
    e.de = de;
    if (de) begin
      e.r = chan(yv + 459 * v);
      e.g = chan(yv - 55 * u - 136 * v);
      e.b = chan(yv + 541 * u);
    end else begin
      e.r = 8'd0;
      e.g = 8'd0;
      e.b = 8'd0;
    end
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.r = 8'd0;
    e.g = 8'd0;
    e.b = 8'd0;
    e.hs = 1'b0;
    e.vs = 1'b0;
    e.de = 1'b0;
    return e;
  endfunction

  task automatic step(input logic rst, input logic [7:0] y,
                      input logic [7:0] cb, input logic [7:0] cr,
                      input logic hs, input logic vs, input logic de,
                      input bit lit, input logic [7:0] lr,
                      input logic [7:0] lg, input logic [7:0] lb);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    ycbcr_y  = y;
    ycbcr_cb = cb;
    ycbcr_cr = cr;
    ycbcr_hs = hs;
    ycbcr_vs = vs;
    ycbcr_de = de;
    e = model(int'(y), int'(cb), int'(cr), hs, vs, de);
    if (lit) begin
      e.r = lr;
      e.g = lg;
      e.b = lb;
    end
    if (!rst) begin
      foreach (exp_q[i])
        exp_q[i] = zero_exp();
      e = zero_exp();
    end
    exp_q.push_back(e);
    running = 1;
  endtask

  always @(posedge clk) begin
    #1;
    if (running) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL queue_empty: no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de} !==
            {e.r, e.g, e.b, e.hs, e.vs, e.de}) begin
          n_fail++;
          $display("FAIL pixel @%0t: got r=%0d g=%0d b=%0d hs=%b vs=%b de=%b, want r=%0d g=%0d b=%0d hs=%b vs=%b de=%b",
                   $time, rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de,
                   e.r, e.g, e.b, e.hs, e.vs, e.de);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    ycbcr_y  = '0;
    ycbcr_cb = '0;
    ycbcr_cr = '0;
    ycbcr_hs = 1'b0;
    ycbcr_vs = 1'b0;
    ycbcr_de = 1'b0;
    repeat (3) exp_q.push_back(zero_exp());

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(1, 16,  128, 128, 0, 0, 1, 1, 0,   0,   0);
    step(1, 235, 128, 128, 0, 0, 1, 1, 255, 255, 255);
    step(1, 126, 128, 128, 0, 0, 1, 1, 128, 128, 128);
    step(1, 63,  102, 240, 0, 0, 1, 1, 255, 1,   0);
    step(1, 0,   0,   0,   0, 0, 1, 1, 0,   77,  0);
    step(1, 255, 255, 255, 0, 0, 1, 1, 255, 183, 255);
    step(1, 16,  128, 128, 1, 1, 0, 0, 0,   0,   0);

    for (int i = 0; i < 10000; i++) begin
      int   pos;
      logic hs, vs, de, rst;
      pos = i % 40;
      hs  = (pos == 0);
      vs  = ((i / 40) % 12) < 3;
      de  = (pos >= 4) && ($urandom_range(0, 7) != 0);
      rst = !(i == 5003 || i == 7777);
      if (!rst)
        de = 1'b1;
      step(rst, 8'($urandom), 8'($urandom), 8'($urandom),
           hs, vs, de, 0, 0, 0, 0);
    end

    repeat (6) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    running = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ycbcr_to_rgb.md
Name: ycbcr_to_rgb

Overview:
- Pipelined inverse colour-space converter. Takes 8-bit limited-range BT.709 YCbCr plus hs/vs/de and returns 8-bit RGB888 with matched, delayed sync.
- Sits after YCbCr-domain processing (grey/threshold/filter stages) and before the video output/encoder path.
- Accepts one pixel per clock and outputs one pixel per clock, with fixed latency and no stalls.
- Fixed-point scale is x256. Equations:
  - R = 1.164(Y-16) + 1.793(Cr-128)
  - G = 1.164(Y-16) - 0.213(Cb-128) - 0.533(Cr-128)
  - B = 1.164(Y-16) + 2.112(Cb-128)

Parameters:
- BLANK_ZERO, 1, when 1 force rgb_r/g/b to 0 on any cycle where output rgb_de is 0; when 0 pass the computed value through.
- C_Y, 298, Y gain (1.164*256).
- C_RV, 459, Cr->R gain (1.793*256).
- C_GU, 55, Cb->G gain (0.213*256).
- C_GV, 136, Cr->G gain (0.533*256).
- C_BU, 541, Cb->B gain (2.112*256).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- ycbcr_y  in  8  luma
- ycbcr_cb  in  8  blue-difference chroma
- ycbcr_cr  in  8  red-difference chroma
- ycbcr_hs  in  1  horizontal sync
- ycbcr_vs  in  1  vertical sync
- ycbcr_de  in  1  data enable
- rgb_r  out  8  red
- rgb_g  out  8  green
- rgb_b  out  8  blue
- rgb_hs  out  1  ycbcr_hs delayed 4 clocks
- rgb_vs  out  1  ycbcr_vs delayed 4 clocks
- rgb_de  out  1  ycbcr_de delayed 4 clocks

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low. Every register clears only on a clk edge with rst_n=0.
- Reset values: every pipeline register is 0, so rgb_r/g/b and rgb_hs/vs/de are all 0 during reset and on the first edge after release. After release, the pipeline holds zeros until real data propagates.
- S1, offsets:
  - yo = Y-16, 9-bit signed (-16..239).
  - uo = Cb-128 and vo = Cr-128, 9-bit signed (-128..127).
- S2, products: register five signed products (C_Y*yo, C_RV*vo, C_GU*uo, C_GV*vo, C_BU*uo), each 20-bit signed.
- S3, sums: 20-bit signed sums; no overflow is possible (range -74016..+139929).
  - sR = Yp + RVp
  - sG = Yp - GUp - GVp
  - sB = Yp + BUp
- S4, round and clamp, per channel:
  - t = (s + 128) >>> 8, arithmetic shift.
  - If t < 0, output 0; if t > 255, output 255; otherwise output t[7:0].
- Latency: exactly 4 clocks from input sample to output pixel. hs/vs/de use a 4-deep shift register and must stay cycle-aligned with the pixel data.
- No handshake or back-pressure: a new pixel is accepted every clock regardless of de.
- Blanking: the arithmetic runs on every cycle. Only the S4 output mux applies BLANK_ZERO, using the delayed de.
- Reset asserted mid-frame: the next edge clears all stages, including the sync delays. Pixels in flight are discarded, and there is no partial or stale output after reset releases.
- Input sync pulses of 1 clock width must appear at the output as exactly 1 clock wide, with no merging or loss. Back-to-back toggles of de must be preserved bit-exactly.

Decomposition:
- Shared package ycbcr_pkg:
  - Coefficient constants: C_Y, C_RV, C_GU, C_GV, C_BU.
  - Offsets Y_OFS=16 and C_OFS=128.
  - Rounding constant 128, PIPE_LAT=4, and a signed 20-bit sum typedef.
  - The forward-converter constants belong here too.
- One natural sub-module: sync_delay, a parameterised N-stage shift of {hs,vs,de} with synchronous active-low clear. Here it is instantiated with N=4. It is reusable by the forward converter and other stages.

Test Plan:
- Black, white and grey: Y/Cb/Cr = 16/128/128 -> RGB 0/0/0. 235/128/128 -> 255/255/255. 126/128/128 -> 128/128/128. Each appears exactly 4 clocks after input.
- BT.709 red: 63/102/240 -> R=255 (clamped from 256), G=1, B=0.
- Clamp extremes: 0/0/0 -> 0/77/0. 255/255/255 -> 255/183/255.
- Sync alignment: random pixel stream with single-clock hs pulses, a multi-line vs, and gapped de -> outputs match the inputs delayed 4 clocks. With BLANK_ZERO=1, RGB is 0 wherever rgb_de=0.
- Reset mid-stream: assert rst_n=0 for 1 clock during active de=1 video -> on the next edge all outputs are 0. After release, outputs stay 0 for 4 clocks, then track new input.
- Randomised: 10k random pixels compared against a reference model of the integer equations above -> zero mismatches.
